// File: rtl/uart_core_cfg_if.sv
// Host-side handshake bundle for uart_core_cfg.
//   master : host / test side  - drives tx_data, tx_valid, rx_ready
//   slave  : UART core side    - drives tx_ready, tx_done, rx_data, rx_valid,
//                                rx_parity_err, rx_frame_err, rx_overrun
interface uart_core_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface

// File: rtl/uart_core_cfg.sv
// Configurable full-duplex UART core: shared baud tick generator, transmitter
// and 16x-oversampling receiver with optional internal loopback (tx -> rx).
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   loopback  1 = receiver listens to the internal tx line instead of rx
//   host      handshake bundle (tx_data/valid/ready/done, rx_data/valid/ready,
//             rx_parity_err, rx_frame_err, rx_overrun)
//   tx        serial output, idle high
//   rx        serial input, asynchronous
//
// FSM states (shared encoding for TX and RX):
//   state    | meaning
//   S_IDLE   | line idle; TX accepts a word, RX waits for a falling edge
//   S_START  | start bit (TX drives 0; RX waits for start-bit centre)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (only when parity is enabled)
//   S_STOP   | stop bit(s); RX leaves right after the first stop-bit centre
module uart_core_cfg #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           loopback,
    uart_core_cfg_if.slave host,
    output logic           tx,
    input  logic           rx
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic             HAS_PAR  = (PARITY_EN != 0);
    localparam logic             PAR_ODD  = (PARITY_ODD != 0);
    localparam logic             TWO_STOP = (STOP_BITS == 2);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    generate
        if (DIV < 1) begin : g_div_chk
            $error("uart_core_cfg: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
            $error("uart_core_cfg: DATA_BITS must be 5..9");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
            $error("uart_core_cfg: OVERSAMPLE must be even and >= 8");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
            $error("uart_core_cfg: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ---------------- baud tick ----------------
    logic [CNT_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    state_t               tx_state, tx_state_nxt;
    logic [OS_W-1:0]      tx_os, tx_os_nxt;
    logic [BIT_W-1:0]     tx_bit, tx_bit_nxt;
    logic                 tx_stop, tx_stop_nxt;
    logic [DATA_BITS-1:0] tx_shreg, tx_shreg_nxt;
    logic                 tx_par, tx_par_nxt;
    logic                 tx_nxt;
    logic                 tx_done_q, tx_done_nxt;
    logic                 tx_rdy;
    logic                 tx_bit_end;

    // Ready is masked by rst so it reads 0 throughout reset and 1 on the
    // first cycle after release.
    assign tx_rdy     = !rst && (tx_state == S_IDLE);
    assign tx_bit_end = tick && (tx_os == '0);

    always_comb begin
        tx_state_nxt = tx_state;
        tx_os_nxt    = tx_os;
        tx_bit_nxt   = tx_bit;
        tx_stop_nxt  = tx_stop;
        tx_shreg_nxt = tx_shreg;
        tx_par_nxt   = tx_par;
        tx_done_nxt  = 1'b0;
        tx_nxt       = 1'b1;

        if (tx_state != S_IDLE && tick)
            tx_os_nxt = tx_bit_end ? OS_LAST : tx_os - 1'b1;

        case (tx_state)
            S_IDLE: begin
                if (host.tx_valid && tx_rdy) begin
                    tx_state_nxt = S_START;
                    tx_shreg_nxt = host.tx_data;
                    tx_par_nxt   = (^host.tx_data) ^ PAR_ODD;
                    tx_os_nxt    = OS_LAST;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_nxt = S_DATA;
                    tx_bit_nxt   = BIT_LAST;
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    tx_shreg_nxt = {1'b0, tx_shreg[DATA_BITS-1:1]};
                    if (tx_bit == '0) begin
                        tx_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
                        tx_stop_nxt  = TWO_STOP;
                    end else begin
                        tx_bit_nxt = tx_bit - 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_nxt = S_STOP;
                    tx_stop_nxt  = TWO_STOP;
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    if (!tx_stop) begin
                        tx_state_nxt = S_IDLE;
                        tx_done_nxt  = 1'b1;
                    end else begin
                        tx_stop_nxt = 1'b0;
                    end
                end
            end
            default: tx_state_nxt = S_IDLE;
        endcase

        // Line level is registered from the next state so tx never glitches.
        case (tx_state_nxt)
            S_START:  tx_nxt = 1'b0;
            S_DATA:   tx_nxt = tx_shreg_nxt[0];
            S_PARITY: tx_nxt = tx_par;
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state  <= S_IDLE;
            tx_os     <= '0;
            tx_bit    <= '0;
            tx_stop   <= 1'b0;
            tx_shreg  <= '0;
            tx_par    <= 1'b0;
            tx        <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_state  <= tx_state_nxt;
            tx_os     <= tx_os_nxt;
            tx_bit    <= tx_bit_nxt;
            tx_stop   <= tx_stop_nxt;
            tx_shreg  <= tx_shreg_nxt;
            tx_par    <= tx_par_nxt;
            tx        <= tx_nxt;
            tx_done_q <= tx_done_nxt;
        end
    end

    assign host.tx_ready = tx_rdy;
    assign host.tx_done  = tx_done_q;

    // ---------------- receiver ----------------
    logic [1:0]           rx_sync;
    logic                 rx_s;
    state_t               rx_state, rx_state_nxt;
    logic [OS_W-1:0]      rx_os, rx_os_nxt;
    logic [BIT_W-1:0]     rx_bit, rx_bit_nxt;
    logic [DATA_BITS-1:0] rx_shreg, rx_shreg_nxt;
    logic                 rx_par, rx_par_nxt;
    logic                 rx_cmp;
    logic                 rx_sample;

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) rx_sync <= 2'b11;
        else     rx_sync <= {rx_sync[0], loopback ? tx : rx};
    end

    assign rx_s      = rx_sync[1];
    assign rx_sample = tick && (rx_os == '0);

    always_comb begin
        rx_state_nxt = rx_state;
        rx_os_nxt    = rx_os;
        rx_bit_nxt   = rx_bit;
        rx_shreg_nxt = rx_shreg;
        rx_par_nxt   = rx_par;
        rx_cmp       = 1'b0;

        if (rx_state != S_IDLE && tick && rx_os != '0)
            rx_os_nxt = rx_os - 1'b1;

        case (rx_state)
            S_IDLE: begin
                if (!rx_s) begin
                    rx_state_nxt = S_START;
                    rx_os_nxt    = OS_HALF;
                end
            end
            S_START: begin
                if (rx_sample) begin
                    if (rx_s) begin
                        rx_state_nxt = S_IDLE;
                    end else begin
                        rx_state_nxt = S_DATA;
                        rx_os_nxt    = OS_LAST;
                        rx_bit_nxt   = BIT_LAST;
                    end
                end
            end
            S_DATA: begin
                if (rx_sample) begin
                    rx_shreg_nxt = {rx_s, rx_shreg[DATA_BITS-1:1]};
                    rx_os_nxt    = OS_LAST;
                    if (rx_bit == '0) rx_state_nxt = HAS_PAR ? S_PARITY : S_STOP;
                    else              rx_bit_nxt   = rx_bit - 1'b1;
                end
            end
            S_PARITY: begin
                if (rx_sample) begin
                    rx_par_nxt   = rx_s;
                    rx_os_nxt    = OS_LAST;
                    rx_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_sample) begin
                    rx_state_nxt = S_IDLE;
                    rx_cmp       = 1'b1;
                end
            end
            default: rx_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= S_IDLE;
            rx_os    <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_os    <= rx_os_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_shreg <= rx_shreg_nxt;
            rx_par   <= rx_par_nxt;
        end
    end

    // Output holding register: an accept in the completion cycle frees the
    // slot, so the new frame is loaded instead of being flagged as overrun.
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_perr_q, rx_ferr_q, rx_ovr_q;
    logic                 rx_accept;

    assign rx_accept = rx_valid_q && host.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_ovr_q <= 1'b0;
            if (rx_cmp && (!rx_valid_q || rx_accept)) begin
                rx_data_q  <= rx_shreg;
                rx_perr_q  <= HAS_PAR && (rx_par != ((^rx_shreg) ^ PAR_ODD));
                rx_ferr_q  <= !rx_s;
                rx_valid_q <= 1'b1;
            end else begin
                if (rx_cmp)    rx_ovr_q   <= 1'b1;
                if (rx_accept) rx_valid_q <= 1'b0;
            end
        end
    end

    assign host.rx_data       = rx_data_q;
    assign host.rx_valid      = rx_valid_q;
    assign host.rx_parity_err = rx_perr_q;
    assign host.rx_frame_err  = rx_ferr_q;
    assign host.rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg: one 8N1 instance (loopback and rx-pin
// tests) and one 8E1 instance for parity / break checks. DIV = 10, bit = 160 clk.
module tb_uart_core_cfg;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 160;

    logic clk = 1'b0;
    logic rst;
    logic lb, lb_p;
    logic rx_u, rx_p;
    logic tx_u, tx_p;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_core_cfg_if #(.DATA_BITS(8)) ifc ();
    uart_core_cfg_if #(.DATA_BITS(8)) ifp ();

    uart_core_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) u_dut (
        .clk(clk), .rst(rst), .loopback(lb), .host(ifc), .tx(tx_u), .rx(rx_u)
    );

    uart_core_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
        .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) u_par (
        .clk(clk), .rst(rst), .loopback(lb_p), .host(ifp), .tx(tx_p), .rx(rx_p)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pin(input bit sel, input logic b);
        if (sel) rx_p = b;
        else     rx_u = b;
        cyc(BIT_CLKS);
    endtask

    // start, 8 data LSB first, optional parity, stop, one idle bit
    task automatic drive_frame(input bit sel, input logic [7:0] d, input bit use_par,
                               input logic par, input logic stop);
        set_pin(sel, 1'b0);
        for (int i = 0; i < 8; i++) set_pin(sel, d[i]);
        if (use_par) set_pin(sel, par);
        set_pin(sel, stop);
        set_pin(sel, 1'b1);
    endtask

    task automatic send_u(input logic [7:0] d);
        int n = 0;
        while (ifc.tx_ready !== 1'b1 && n < 4000) begin
            cyc(1);
            n++;
        end
        ifc.tx_data  = d;
        ifc.tx_valid = 1'b1;
        cyc(1);
        ifc.tx_valid = 1'b0;
        ifc.tx_data  = 8'h00;
    endtask

    // Cycles from the handshake edge to the tx_done cycle; also counts overrun pulses.
    task automatic wait_done_u(input int limit, output int n, output int ovr);
        n   = 0;
        ovr = 0;
        do begin
            cyc(1);
            n++;
            if (ifc.rx_overrun === 1'b1) ovr++;
        end while (ifc.tx_done !== 1'b1 && n < limit);
    endtask

    task automatic test_reset();
        rst = 1'b1; lb = 1'b0; lb_p = 1'b0; rx_u = 1'b1; rx_p = 1'b1;
        ifc.tx_valid = 1'b0; ifc.tx_data = 8'h00; ifc.rx_ready = 1'b0;
        ifp.tx_valid = 1'b0; ifp.tx_data = 8'h00; ifp.rx_ready = 1'b0;
        cyc(3);
        vectors++;
        if (ifc.tx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_rst: got %b expected 0", ifc.tx_ready); end
        rst = 1'b0;
        #1;
        vectors++;
        if (ifc.tx_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_first: got %b expected 1", ifc.tx_ready); end
        cyc(1);
        vectors++;
        if (tx_u !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b expected 1", tx_u); end
        vectors++;
        if ({ifc.rx_valid, ifc.tx_done, ifc.rx_overrun, ifc.rx_parity_err, ifc.rx_frame_err} !== 5'b0)
            begin miscompares++; $display("FAIL reset_flags: got %b expected 00000",
                {ifc.rx_valid, ifc.tx_done, ifc.rx_overrun, ifc.rx_parity_err, ifc.rx_frame_err}); end
        vectors++;
        if (ifc.rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h expected 00", ifc.rx_data); end
    endtask

    task automatic test_loopback();
        int n, ovr;
        lb = 1'b1;
        cyc(2);
        send_u(8'hA5);
        vectors++;
        if (tx_u !== 1'b0) begin miscompares++; $display("FAIL lb_start_low: got %b expected 0", tx_u); end
        wait_done_u(2000, n, ovr);
        vectors++;
        if (n < 1591 || n > 1600) begin miscompares++; $display("FAIL lb_done_time: got %0d expected 1591..1600", n); end
        vectors++;
        if (ifc.tx_ready !== 1'b1) begin miscompares++; $display("FAIL lb_ready_at_done: got %b expected 1", ifc.tx_ready); end
        vectors++;
        if (ifc.rx_valid !== 1'b1) begin miscompares++; $display("FAIL lb_rx_valid: got %b expected 1", ifc.rx_valid); end
        vectors++;
        if (ifc.rx_data !== 8'hA5) begin miscompares++; $display("FAIL lb_rx_data: got %h expected a5", ifc.rx_data); end
        vectors++;
        if ({ifc.rx_parity_err, ifc.rx_frame_err} !== 2'b00)
            begin miscompares++; $display("FAIL lb_errs: got %b expected 00", {ifc.rx_parity_err, ifc.rx_frame_err}); end
        cyc(1);
        vectors++;
        if (ifc.tx_done !== 1'b0) begin miscompares++; $display("FAIL lb_done_pulse: got %b expected 0", ifc.tx_done); end
        ifc.rx_ready = 1'b1;
        cyc(1);
        ifc.rx_ready = 1'b0;
        vectors++;
        if (ifc.rx_valid !== 1'b0) begin miscompares++; $display("FAIL lb_accept: got %b expected 0", ifc.rx_valid); end
    endtask

    task automatic test_parity();
        // 0x3C has four ones: even parity bit is 0, so sending 1 is an error
        drive_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (ifp.rx_valid !== 1'b1) begin miscompares++; $display("FAIL par_bad_valid: got %b expected 1", ifp.rx_valid); end
        vectors++;
        if (ifp.rx_data !== 8'h3C) begin miscompares++; $display("FAIL par_bad_data: got %h expected 3c", ifp.rx_data); end
        vectors++;
        if ({ifp.rx_parity_err, ifp.rx_frame_err} !== 2'b10)
            begin miscompares++; $display("FAIL par_bad_errs: got %b expected 10", {ifp.rx_parity_err, ifp.rx_frame_err}); end
        ifp.rx_ready = 1'b1; cyc(1); ifp.rx_ready = 1'b0;

        drive_frame(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({ifp.rx_valid, ifp.rx_parity_err, ifp.rx_frame_err} !== 3'b100)
            begin miscompares++; $display("FAIL par_good_flags: got %b expected 100",
                {ifp.rx_valid, ifp.rx_parity_err, ifp.rx_frame_err}); end
        ifp.rx_ready = 1'b1; cyc(1); ifp.rx_ready = 1'b0;

        // break: all zero data, parity 0 (correct for even), stop low
        drive_frame(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({ifp.rx_valid, ifp.rx_parity_err, ifp.rx_frame_err} !== 3'b101)
            begin miscompares++; $display("FAIL break_flags: got %b expected 101",
                {ifp.rx_valid, ifp.rx_parity_err, ifp.rx_frame_err}); end
        vectors++;
        if (ifp.rx_data !== 8'h00) begin miscompares++; $display("FAIL break_data: got %h expected 00", ifp.rx_data); end
    endtask

    task automatic test_back_to_back();
        int n1, n2, o1, o2;
        lb = 1'b1;
        ifc.rx_ready = 1'b0;
        send_u(8'h11);
        wait_done_u(2000, n1, o1);
        send_u(8'h22);
        wait_done_u(2000, n2, o2);
        cyc(50);
        vectors++;
        if (n2 < 1591 || n2 > 1600) begin miscompares++; $display("FAIL b2b_done_time: got %0d expected 1591..1600", n2); end
        vectors++;
        if (ifc.rx_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b expected 1", ifc.rx_valid); end
        vectors++;
        if (ifc.rx_data !== 8'h11) begin miscompares++; $display("FAIL b2b_held_data: got %h expected 11", ifc.rx_data); end
        vectors++;
        if (o1 + o2 !== 1) begin miscompares++; $display("FAIL b2b_overrun_count: got %0d expected 1", o1 + o2); end
        ifc.rx_ready = 1'b1; cyc(1); ifc.rx_ready = 1'b0;
        vectors++;
        if (ifc.rx_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got %b expected 0", ifc.rx_valid); end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        lb   = 1'b0;
        rx_u = 1'b1;
        cyc(5);
        rx_u = 1'b0;
        cyc(40);
        rx_u = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (ifc.rx_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin miscompares++; $display("FAIL glitch_no_valid: got %b expected 0", seen); end
        drive_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (ifc.rx_valid !== 1'b1) begin miscompares++; $display("FAIL glitch_next_valid: got %b expected 1", ifc.rx_valid); end
        vectors++;
        if (ifc.rx_data !== 8'h5A) begin miscompares++; $display("FAIL glitch_next_data: got %h expected 5a", ifc.rx_data); end
        vectors++;
        if (ifc.rx_frame_err !== 1'b0) begin miscompares++; $display("FAIL glitch_next_ferr: got %b expected 0", ifc.rx_frame_err); end
        ifc.rx_ready = 1'b1; cyc(1); ifc.rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        bit done_seen  = 1'b0;
        bit valid_seen = 1'b0;
        lb = 1'b1;
        cyc(2);
        send_u(8'hF0);
        cyc(719);
        // 720 clk after the handshake is inside data bit 3, which is 0 for 0xF0
        vectors++;
        if (tx_u !== 1'b0) begin miscompares++; $display("FAIL rstmid_bit3: got %b expected 0", tx_u); end
        rst = 1'b1;
        cyc(1);
        vectors++;
        if (tx_u !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx_high: got %b expected 1", tx_u); end
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            cyc(1);
            if (ifc.tx_done === 1'b1) done_seen = 1'b1;
            if (ifc.rx_valid === 1'b1) valid_seen = 1'b1;
        end
        vectors++;
        if (done_seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_done: got %b expected 0", done_seen); end
        vectors++;
        if (valid_seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_valid: got %b expected 0", valid_seen); end
        vectors++;
        if (ifc.tx_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b expected 1", ifc.tx_ready); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_parity();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
